washer_sequencer: RTL and testbench

Program sequencer for the washer's DC motor function. It runs a selected wash program as an ordered list of motor stages, driving the mode input of the motor-function block and waiting for its finish flag. It sits between the user/AXI register interface and the motor-function/PWM/FND chain, and handles start, pause/resume, abort and an optional watchdog.

---
 rtl/washer_sequencer.sv | 158 +++++++++++++++
 tb/tb_washer_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/washer_sequencer.sv
// Wash-program sequencer: steps the motor-function block through the stage list of the
// selected program. Optional per-stage watchdog enabled by defining WASHER_SEQ_TIMEOUT_EN.
module washer_sequencer #(
    parameter logic [31:0] GAP_CYCLES     = 32'd100_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_abort,
    input  logic [1:0] i_program,
    input  logic       i_fin,
    output logic [2:0] o_mode,
    output logic [1:0] o_stage,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    // state | meaning
    // IDLE  | waiting for start, motor stopped
    // LOAD  | arming: wait for the finish flag to drop before running the stage
    // RUN   | motor driven with the current stage's mode
    // GAP   | stopped pause between two stages
    // PAUSE | user pause; stage restarts from its beginning on release
    // DONE  | program complete
    // ERROR | watchdog expired; only abort or reset leaves
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_GAP, S_PAUSE, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  prog, prog_nxt;
    logic [1:0]  stage, stage_nxt;
    logic [2:0]  mode_nxt;
    logic [31:0] gap_cnt;
    logic        gap_expired;
    logic        timeout;
    logic        err_nxt;

    function automatic logic [2:0] stage_mode(input logic [1:0] p, input logic [1:0] s);
        case (p)
            2'd0:    stage_mode = (s == 2'd0) ? 3'd1 : ((s == 2'd1) ? 3'd2 : 3'd3);
            2'd1:    stage_mode = (s == 2'd0) ? 3'd1 : 3'd3;
            2'd2:    stage_mode = (s == 2'd0) ? 3'd2 : 3'd3;
            default: stage_mode = 3'd3;
        endcase
    endfunction

    function automatic logic [1:0] last_stage(input logic [1:0] p);
        case (p)
            2'd0:    last_stage = 2'd2;
            2'd3:    last_stage = 2'd0;
            default: last_stage = 2'd1;
        endcase
    endfunction

    // A zero gap setting still spends one cycle in GAP.
    assign gap_expired = (GAP_CYCLES == 32'd0) || (gap_cnt == GAP_CYCLES - 32'd1);

`ifdef WASHER_SEQ_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wd_cnt <= 32'd0;
        end else if (state != S_RUN) begin
            wd_cnt <= 32'd0;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign timeout = (state == S_RUN) &&
                     ((TIMEOUT_CYCLES == 32'd0) || (wd_cnt == TIMEOUT_CYCLES - 32'd1));
    assign err_nxt = (state_nxt == S_ERROR);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err_nxt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        prog_nxt  = prog;
        stage_nxt = stage;
        if (i_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_nxt = S_LOAD;
                        prog_nxt  = i_program;
                        stage_nxt = 2'd0;
                    end
                end
                S_LOAD: begin
                    if (i_pause)     state_nxt = S_PAUSE;
                    else if (!i_fin) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (i_pause) begin
                        state_nxt = S_PAUSE;
                    end else if (i_fin) begin
                        if (stage == last_stage(prog)) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_GAP;
                            stage_nxt = stage + 2'd1;
                        end
                    end else if (timeout) begin
                        state_nxt = S_ERROR;
                    end
                end
                S_GAP: begin
                    if (i_pause)          state_nxt = S_PAUSE;
                    else if (gap_expired) state_nxt = S_LOAD;
                end
                S_PAUSE: begin
                    if (!i_pause) state_nxt = S_LOAD;
                end
                S_ERROR: state_nxt = S_ERROR;
                default: state_nxt = S_IDLE;
            endcase
        end
        mode_nxt = (state_nxt == S_RUN) ? stage_mode(prog_nxt, stage_nxt) : 3'd0;
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            prog    <= 2'd0;
            stage   <= 2'd0;
            gap_cnt <= 32'd0;
            o_mode  <= 3'd0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            prog    <= prog_nxt;
            stage   <= stage_nxt;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 32'd1 : 32'd0;
            o_mode  <= mode_nxt;
            o_busy  <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                       (state_nxt == S_GAP)  || (state_nxt == S_PAUSE);
            o_done  <= (state_nxt == S_DONE);
            o_err   <= err_nxt;
        end
    end

    assign o_stage = stage;

endmodule

// File: tb/tb_washer_sequencer.sv
// Bench for washer_sequencer: stimulus table plus hand-written sequences, checked through
// an expected-output queue. Timeout section follows WASHER_SEQ_TIMEOUT_EN.
module tb_washer_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_abort = 1'b0;
    logic [1:0] i_program = 2'd0;
    logic       i_fin = 1'b0;
    logic [2:0] o_mode;
    logic [1:0] o_stage;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int errors = 0;
    int checks = 0;

    // flags = {stage_dont_care, busy, done, err}; inp = {start, pause, abort, fin}
    typedef struct {
        string      name;
        logic [3:0] inp;
        logic [1:0] prog;
        logic [2:0] mode;
        logic [1:0] stage;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] mode;
        logic [1:0] stage;
        logic [3:0] flags;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    washer_sequencer #(
        .GAP_CYCLES    (32'd4),
        .TIMEOUT_CYCLES(32'd20)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_pause  (i_pause),
        .i_abort  (i_abort),
        .i_program(i_program),
        .i_fin    (i_fin),
        .o_mode   (o_mode),
        .o_stage  (o_stage),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic push_exp(input string nm, input logic [2:0] m, input logic [1:0] sg,
                            input logic [3:0] fl);
        exp_t e;
        e.name  = nm;
        e.mode  = m;
        e.stage = sg;
        e.flags = fl;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        logic bad;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        checks++;
        bad = (o_mode !== e.mode) || (o_busy !== e.flags[2]) || (o_done !== e.flags[1]) ||
              (o_err !== e.flags[0]) || (!e.flags[3] && (o_stage !== e.stage));
        if (bad) begin
            errors++;
            $display("FAIL %s: got mode=%0d stage=%0d busy=%0b done=%0b err=%0b, expected mode=%0d stage=%0d%s busy=%0b done=%0b err=%0b",
                     e.name, o_mode, o_stage, o_busy, o_done, o_err, e.mode, e.stage,
                     e.flags[3] ? "(any)" : "", e.flags[2], e.flags[1], e.flags[0]);
        end
    endtask

    task automatic apply(input string nm, input logic [3:0] inp, input logic [1:0] pg,
                         input logic [2:0] m, input logic [1:0] sg, input logic [3:0] fl);
        {i_start, i_pause, i_abort, i_fin} = inp;
        i_program = pg;
        push_exp(nm, m, sg, fl);
        @(posedge i_clk);
        #1;
        pop_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        tbl.push_back('{"p3_start_stale_fin",     4'b1001, 2'd3, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p3_load_hold",           4'b0001, 2'd3, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p3_load_hold2",          4'b0001, 2'd3, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p3_fin_drop_run",        4'b0000, 2'd3, 3'd3, 2'd0, 4'b0100});
        tbl.push_back('{"p3_run",                 4'b0000, 2'd3, 3'd3, 2'd0, 4'b0100});
        tbl.push_back('{"p3_done",                4'b0001, 2'd3, 3'd0, 2'd0, 4'b0010});
        tbl.push_back('{"p3_done_hold",           4'b0000, 2'd3, 3'd0, 2'd0, 4'b0010});
        tbl.push_back('{"p1_start_from_done",     4'b1000, 2'd1, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p1_run_wash",            4'b0000, 2'd1, 3'd1, 2'd0, 4'b0100});
        tbl.push_back('{"p1_run_wash2",           4'b0000, 2'd1, 3'd1, 2'd0, 4'b0100});
        tbl.push_back('{"p1_pause",               4'b0100, 2'd1, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p1_pause_hold",          4'b0100, 2'd1, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p1_release_load",        4'b0000, 2'd1, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p1_resume_wash",         4'b0000, 2'd1, 3'd1, 2'd0, 4'b0100});
        tbl.push_back('{"p1_fin_gap",             4'b0001, 2'd1, 3'd0, 2'd1, 4'b0100});
        tbl.push_back('{"p1_pause_in_gap",        4'b0100, 2'd1, 3'd0, 2'd1, 4'b0100});
        tbl.push_back('{"p1_release_load_spin",   4'b0000, 2'd1, 3'd0, 2'd1, 4'b0100});
        tbl.push_back('{"p1_run_spin",            4'b0000, 2'd1, 3'd3, 2'd1, 4'b0100});
        tbl.push_back('{"p1_pause_beats_fin",     4'b0101, 2'd1, 3'd0, 2'd1, 4'b0100});
        tbl.push_back('{"p1_release_stale_fin",   4'b0001, 2'd1, 3'd0, 2'd1, 4'b0100});
        tbl.push_back('{"p1_load_hold",           4'b0001, 2'd1, 3'd0, 2'd1, 4'b0100});
        tbl.push_back('{"p1_run_spin2",           4'b0000, 2'd1, 3'd3, 2'd1, 4'b0100});
        tbl.push_back('{"p1_done",                4'b0001, 2'd1, 3'd0, 2'd1, 4'b0010});
        tbl.push_back('{"done_abort_beats_start", 4'b1010, 2'd2, 3'd0, 2'd0, 4'b1000});
        tbl.push_back('{"p2_start",               4'b1000, 2'd2, 3'd0, 2'd0, 4'b0100});
        tbl.push_back('{"p2_run_rinse",           4'b0000, 2'd2, 3'd2, 2'd0, 4'b0100});
        tbl.push_back('{"p2_abort",               4'b0010, 2'd2, 3'd0, 2'd0, 4'b1000});
        tbl.push_back('{"idle_pause_ignored",     4'b0100, 2'd2, 3'd0, 2'd0, 4'b1000});
        tbl.push_back('{"idle_hold",              4'b0000, 2'd2, 3'd0, 2'd0, 4'b1000});

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        push_exp("reset_values", 3'd0, 2'd0, 4'b0000);
        pop_check();
        i_reset = 1'b1;
        apply("idle_no_start", 4'b0000, 2'd0, 3'd0, 2'd0, 4'b0000);

        foreach (tbl[i])
            apply(tbl[i].name, tbl[i].inp, tbl[i].prog, tbl[i].mode, tbl[i].stage, tbl[i].flags);

        // Program 0: 10 RUN cycles per stage, fin pulse, 5 stopped cycles between stages
        apply("p0_start", 4'b1000, 2'd0, 3'd0, 2'd0, 4'b0100);
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 10; k++)
                apply("p0_run", 4'b0000, 2'd0, 3'(s + 1), 2'(s), 4'b0100);
            if (s < 2) begin
                apply("p0_fin_gap", 4'b0001, 2'd0, 3'd0, 2'(s + 1), 4'b0100);
                for (int k = 0; k < 4; k++)
                    apply("p0_gap_load", 4'b0000, 2'd0, 3'd0, 2'(s + 1), 4'b0100);
            end else begin
                apply("p0_done", 4'b0001, 2'd0, 3'd0, 2'd2, 4'b0010);
            end
        end

        // Abort and fin together in the last stage
        apply("p3_start", 4'b1000, 2'd3, 3'd0, 2'd0, 4'b0100);
        apply("p3_run_last", 4'b0000, 2'd3, 3'd3, 2'd0, 4'b0100);
        apply("abort_beats_fin", 4'b0011, 2'd3, 3'd0, 2'd0, 4'b1000);

        // Watchdog: program 2 with fin never asserted
        apply("wd_start", 4'b1000, 2'd2, 3'd0, 2'd0, 4'b0100);
        apply("wd_run_entry", 4'b0000, 2'd2, 3'd2, 2'd0, 4'b0100);
`ifdef WASHER_SEQ_TIMEOUT_EN
        for (int k = 1; k < 20; k++)
            apply("wd_running", 4'b0000, 2'd2, 3'd2, 2'd0, 4'b0100);
        apply("wd_error", 4'b0000, 2'd2, 3'd0, 2'd0, 4'b1001);
        apply("err_ignores_start", 4'b1000, 2'd2, 3'd0, 2'd0, 4'b1001);
        apply("err_ignores_fin", 4'b0001, 2'd2, 3'd0, 2'd0, 4'b1001);
        apply("err_abort", 4'b0010, 2'd2, 3'd0, 2'd0, 4'b1000);
`else
        for (int k = 1; k < 26; k++)
            apply("no_wd_running", 4'b0000, 2'd2, 3'd2, 2'd0, 4'b0100);
        apply("no_wd_fin_gap", 4'b0001, 2'd2, 3'd0, 2'd1, 4'b0100);
        apply("no_wd_abort", 4'b0010, 2'd2, 3'd0, 2'd0, 4'b1000);
`endif

        // Asynchronous reset in the middle of a GAP
        apply("ar_start", 4'b1000, 2'd0, 3'd0, 2'd0, 4'b0100);
        apply("ar_run", 4'b0000, 2'd0, 3'd1, 2'd0, 4'b0100);
        apply("ar_fin_gap", 4'b0001, 2'd0, 3'd0, 2'd1, 4'b0100);
        apply("ar_gap", 4'b0000, 2'd0, 3'd0, 2'd1, 4'b0100);
        #3;
        i_reset = 1'b0;
        #1;
        push_exp("async_reset_mid_gap", 3'd0, 2'd0, 4'b0000);
        pop_check();
        @(posedge i_clk);
        #1;
        push_exp("reset_held", 3'd0, 2'd0, 4'b0000);
        pop_check();
        i_reset = 1'b1;
        apply("post_reset_idle", 4'b0000, 2'd0, 3'd0, 2'd0, 4'b0000);
        apply("post_reset_start", 4'b1000, 2'd3, 3'd0, 2'd0, 4'b0100);
        apply("post_reset_run", 4'b0000, 2'd3, 3'd3, 2'd0, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
